stop_watch_bcd_n: RTL and testbench
===================================

Name: stop_watch_bcd_n

Overview:
- Parametrised successor to the fixed 3-digit cascaded stopwatch.
- N-digit BCD up/down timer with a programmable tick divisor and a preset load.
- Terminal-count handling is selectable: wrap or saturate with sticky done.
- Lap-hold display register freezes the shown value while counting continues.
- Drives the 7-segment display mux; also usable as a countdown timer in the same board designs.

Parameters:
DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
DVSR, 5000000, clk cycles per count tick (>=2); tick period is exactly DVSR cycles.
DVSR_W, 23, prescaler width; must satisfy 2**DVSR_W >= DVSR.
SATURATE, 0, 0 = wrap at terminal value, 1 = stop at terminal value and assert done.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
go  in  1  level; 1 = run prescaler and counter, 0 = pause (state held)
clr  in  1  pulse/level; zero digits, prescaler, done, lap hold
up  in  1  1 = count up, 0 = count down; sampled every cycle
load  in  1  pulse; preset digits from load_val
load_val  in  4*DIGITS  preset, digit i at [4i+3:4i]
lap  in  1  single-cycle pulse; toggles lap hold
q  out  4*DIGITS  live counter value
disp  out  4*DIGITS  hold value while lap_active, else q
lap_active  out  1  display frozen
done  out  1  SATURATE=1 only: terminal value reached (sticky); tied 0 when SATURATE=0
tick  out  1  one-cycle count-enable strobe (for debug/LED)

Behaviour:
- Reset (sync) values: prescaler=0, all digits=0, hold=0, lap_active=0, done=0, tick=0. Consequently q=disp=0.
- Priority, highest first: reset > clr > load > count. lap is independent of load and count; clr overrides lap.
- Prescaler:
  - Counts 0..DVSR-1 only while go=1.
  - tick=1 combinationally in the cycle where prescaler==DVSR-1 and go=1; the prescaler returns to 0 in the next cycle.
  - go=0 freezes the prescaler, so a resumed tick lands after the remaining cycles, not a fresh period.
  - clr and load zero the prescaler.
- Digit cascade:
  - Digit i is enabled when tick=1 and all digits j<i are at 9 (up=1) or at 0 (down=1 meaning up=0).
  - Up: 9->0. Down: 0->9.
  - Each enabled digit updates in the same clock edge; there are no ripple delays.
  - q is registered, so q changes on the edge ending the tick cycle.
- Terminal value: all digits 9 (up) or all digits 0 (down).
  - SATURATE=0: wraps to all-0 (up) or all-9 (down).
  - SATURATE=1: a tick at the terminal value leaves the digits unchanged and sets done=1.
  - done clears only on reset, clr, or load.
  - Changing up while done=1 leaves done set, but counting resumes in the new direction on the next tick.
- up changed mid-period: takes effect on the next tick; the prescaler is unaffected.
- Load:
  - Digits take load_val on the next edge.
  - Any nibble >9 is loaded as 9.
  - load and tick in the same cycle: load wins and the tick is discarded.
- Lap:
  - lap=1 with lap_active=0: hold<=q (the pre-edge value), lap_active<=1.
  - lap=1 with lap_active=1: lap_active<=0.
  - lap in the same cycle as clr: clr wins, so lap_active=0 and hold=0.
- disp is combinational: hold when lap_active=1, else q.
- clr held high keeps everything zero regardless of go.

Decomposition:
- Shared package stop_watch_pkg:
  - BCD_MAX=4'd9 and BCD_MIN=4'd0 constants.
  - A bcd_t 4-bit type.
  - A function clamp_bcd.
- Sub-module bcd_digit, instantiated DIGITS times via generate.
  - Inputs: clk, reset, clr, ld, ld_val, en, up.
  - Outputs: a 4-bit registered value and max/min flags.
- The top holds the prescaler, the enable-chain AND, terminal/done logic and the lap register.

Test Plan:
- DIGITS=4, DVSR=4, go=1 from reset -> tick every 4th cycle; q=0x0009 after 9 ticks, 0x0010 on the 10th, 0x0100 after 100.
- Down count: load_val=0x0100, up=0, 1 tick -> q=0x0099; at 0x0000 with SATURATE=0, next tick -> 0x9999.
- SATURATE=1 and up: load 0x9998, 2 ticks -> q=0x9999, done=1, stays 0x9999; clr -> q=0, done=0.
- Pause: go=0 for 10 cycles mid-period (prescaler=2) -> q and prescaler frozen; the first tick arrives 1 cycle after go returns; go=0 also blocks tick.
- Lap: q=0x0042, lap pulse -> disp=0x0042, lap_active=1 while q keeps counting; second lap -> disp=q. lap with clr in the same cycle -> lap_active=0, q=0.
- Priority: load (load_val=0x12AB) coincident with tick -> q=0x1299, no increment; reset asserted mid-count -> all outputs 0 next edge.

Source files
------------

// File: rtl/stop_watch_pkg.sv
// Shared BCD types and helpers for the N-digit stopwatch/timer.
package stop_watch_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;
   localparam bcd_t BCD_MIN = 4'd0;

   // Nibbles above 9 are not valid BCD; treat them as the top digit value.
   function automatic bcd_t clamp_bcd(input bcd_t v);
      return (v > BCD_MAX) ? BCD_MAX : v;
   endfunction

endpackage

// File: rtl/stop_watch_bcd_n_digit.sv
// One BCD digit of the cascade: wraps 9->0 up and 0->9 down when enabled.
module bcd_digit
   import stop_watch_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic ld,
   input  bcd_t ld_val,
   input  logic en,
   input  logic up,
   output bcd_t q,
   output logic is_max,
   output logic is_min
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         q <= BCD_MIN;
      end else if (ld) begin
         q <= clamp_bcd(ld_val);
      end else if (en) begin
         if (up)
            q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
         else
            q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
      end
   end

   assign is_max = (q == BCD_MAX);
   assign is_min = (q == BCD_MIN);

endmodule

// File: rtl/stop_watch_bcd_n.sv
// N-digit BCD up/down stopwatch with prescaler, preset load, optional
// saturation with sticky done, and a lap-hold display register.
module stop_watch_bcd_n
   import stop_watch_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int DVSR     = 5000000,
   parameter int DVSR_W   = 23,
   parameter int SATURATE = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  go,
   input  logic                  clr,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  lap,
   output logic [4*DIGITS-1:0]   q,
   output logic [4*DIGITS-1:0]   disp,
   output logic                  lap_active,
   output logic                  done,
   output logic                  tick
);

   localparam logic [DVSR_W-1:0] PRESC_LAST = DVSR_W'(DVSR - 1);

   logic [DVSR_W-1:0]   presc;
   logic [DIGITS-1:0]   max_f;
   logic [DIGITS-1:0]   min_f;
   logic [DIGITS-1:0]   en;
   logic [DIGITS:0]     carry;
   logic                terminal;
   logic                sat_hold;
   logic                done_r;
   logic [4*DIGITS-1:0] hold;

   // Prescaler: frozen while go=0 so a resumed period finishes the remainder.
   always_ff @(posedge clk) begin
      if (reset || clr || load)
         presc <= '0;
      else if (go)
         presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
   end

   assign tick = go && (presc == PRESC_LAST);

   // carry[i] is set when every digit below i sits at its rollover value.
   always_comb begin
      carry    = '0;
      carry[0] = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++)
         carry[i+1] = carry[i] & (up ? max_f[i] : min_f[i]);
   end

   assign terminal = carry[DIGITS];
   assign sat_hold = (SATURATE != 0) && terminal;

   always_comb begin
      en = '0;
      for (int unsigned i = 0; i < DIGITS; i++)
         en[i] = tick & carry[i] & ~sat_hold;
   end

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_digit
         bcd_digit u_digit (
            .clk    (clk),
            .reset  (reset),
            .clr    (clr),
            .ld     (load),
            .ld_val (load_val[4*g +: 4]),
            .en     (en[g]),
            .up     (up),
            .q      (q[4*g +: 4]),
            .is_max (max_f[g]),
            .is_min (min_f[g])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset || clr || load)
         done_r <= 1'b0;
      else if (tick && sat_hold)
         done_r <= 1'b1;
   end

   assign done = (SATURATE != 0) ? done_r : 1'b0;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         hold       <= '0;
         lap_active <= 1'b0;
      end else if (lap) begin
         if (!lap_active) begin
            hold       <= q;
            lap_active <= 1'b1;
         end else begin
            lap_active <= 1'b0;
         end
      end
   end

   assign disp = lap_active ? hold : q;

endmodule

// File: tb/tb_stop_watch_bcd_n.sv
// Directed bench: a wrapping and a saturating instance driven in parallel.
module tb_stop_watch_bcd_n;

   logic        clk = 1'b0;
   logic        reset, go, clr, up, load, lap;
   logic [15:0] load_val;
   logic [15:0] q, disp, q_s, disp_s;
   logic        lap_active, done, tick, lap_active_s, done_s, tick_s;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   stop_watch_bcd_n #(.DIGITS(4), .DVSR(4), .DVSR_W(3), .SATURATE(0)) dut (
      .clk(clk), .reset(reset), .go(go), .clr(clr), .up(up), .load(load),
      .load_val(load_val), .lap(lap), .q(q), .disp(disp),
      .lap_active(lap_active), .done(done), .tick(tick)
   );

   stop_watch_bcd_n #(.DIGITS(4), .DVSR(4), .DVSR_W(3), .SATURATE(1)) dut_sat (
      .clk(clk), .reset(reset), .go(go), .clr(clr), .up(up), .load(load),
      .load_val(load_val), .lap(lap), .q(q_s), .disp(disp_s),
      .lap_active(lap_active_s), .done(done_s), .tick(tick_s)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_load(input logic [15:0] v);
      load_val = v; load = 1'b1;
      step(1);
      load = 1'b0;
      #1;
   endtask

   initial begin
      reset = 1'b1; go = 1'b0; clr = 1'b0; up = 1'b1; load = 1'b0; lap = 1'b0;
      load_val = '0;
      step(2);
      reset = 1'b0;
      #1;
      chk("rst_q", q, 0);
      chk("rst_disp", disp, 0);
      chk("rst_lap", lap_active, 0);
      chk("rst_done_sat", done_s, 0);
      chk("rst_tick", tick, 0);

      // Up count, tick every 4th cycle
      go = 1'b1;
      step(3);
      chk("tick_first", tick, 1);
      step(33);
      chk("up_9", q, 16'h0009);
      chk("tick_idle", tick, 0);
      step(4);
      chk("up_10", q, 16'h0010);
      step(360);
      chk("up_100", q, 16'h0100);

      // Down count and wrap/saturate at zero
      up = 1'b0;
      do_load(16'h0100);
      step(4);
      chk("down_99", q, 16'h0099);
      do_load(16'h0000);
      step(4);
      chk("down_wrap", q, 16'h9999);
      chk("down_sat_q", q_s, 16'h0000);
      chk("down_sat_done", done_s, 1);
      chk("wrap_done_tied", done, 0);

      // Saturating up count
      up = 1'b1;
      do_load(16'h9998);
      chk("load_clr_done", done_s, 0);
      step(4);
      chk("sat_9999", q_s, 16'h9999);
      chk("sat_not_done", done_s, 0);
      step(4);
      chk("sat_hold", q_s, 16'h9999);
      chk("sat_done", done_s, 1);
      chk("wrap_0000", q, 16'h0000);
      step(4);
      chk("sat_stays", q_s, 16'h9999);
      up = 1'b0;
      step(4);
      chk("sat_dir_q", q_s, 16'h9998);
      chk("sat_dir_done", done_s, 1);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      #1;
      chk("clr_q_sat", q_s, 0);
      chk("clr_done_sat", done_s, 0);

      // Pause mid-period at prescaler=2
      up = 1'b1;
      step(2);
      go = 1'b0;
      #1;
      chk("pause_tick", tick, 0);
      step(10);
      chk("pause_q", q, 0);
      go = 1'b1;
      #1;
      chk("resume_no_tick", tick, 0);
      step(1);
      chk("resume_tick", tick, 1);
      chk("resume_q_pre", q, 0);
      step(1);
      chk("resume_q", q, 16'h0001);
      step(3);
      go = 1'b0;
      #1;
      chk("go0_blocks_tick", tick, 0);
      step(2);
      chk("go0_q", q, 16'h0001);
      go = 1'b1;
      step(1);
      chk("go1_q", q, 16'h0002);

      // Lap hold
      do_load(16'h0042);
      lap = 1'b1;
      step(1);
      lap = 1'b0;
      #1;
      chk("lap_on", lap_active, 1);
      chk("lap_disp", disp, 16'h0042);
      step(8);
      chk("lap_q_runs", q, 16'h0044);
      chk("lap_disp_held", disp, 16'h0042);
      lap = 1'b1;
      step(1);
      lap = 1'b0;
      #1;
      chk("lap_off", lap_active, 0);
      chk("lap_disp_live", disp, 16'h0044);
      lap = 1'b1;
      step(1);
      clr = 1'b1;
      step(1);
      lap = 1'b0; clr = 1'b0;
      #1;
      chk("lapclr_active", lap_active, 0);
      chk("lapclr_q", q, 0);
      chk("lapclr_disp", disp, 0);

      // Load coincident with tick
      step(3);
      chk("pri_tick", tick, 1);
      do_load(16'h12AB);
      chk("pri_load", q, 16'h1299);
      step(4);
      chk("pri_next", q, 16'h1300);

      // Reset mid-count
      lap = 1'b1;
      step(1);
      lap = 1'b0;
      step(1);
      reset = 1'b1;
      step(1);
      chk("mid_rst_q", q, 0);
      chk("mid_rst_disp", disp, 0);
      chk("mid_rst_lap", lap_active, 0);
      chk("mid_rst_tick", tick, 0);
      chk("mid_rst_done", done_s, 0);
      reset = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
